// File: rtl/fft_input_loader.sv
// Collects a 32-sample real frame and replays it as the 16 bit-reversed stage-1 butterfly pairs.
// Define FFT_INPUT_LOADER_PINGPONG_EN for two banks so one frame can load while the other drains.
module fft_input_loader #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [3:0]    out_idx,
    output logic          out_last
);

    logic [4:0] wr_cnt;
    logic [3:0] rd_cnt;
    logic [3:0] rd_rev;
    logic       in_fire;
    logic       out_fire;
    logic       wr_done;
    logic       rd_done;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign wr_done  = in_fire && (wr_cnt == 5'd31);
    assign rd_done  = out_fire && (rd_cnt == 4'd15);
    assign rd_rev   = {rd_cnt[0], rd_cnt[1], rd_cnt[2], rd_cnt[3]};
    assign out_idx  = rd_cnt;
    assign out_last = (rd_cnt == 4'd15);

    // Both counters wrap naturally at the end of a frame, so no explicit clear is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (in_fire)
                wr_cnt <= wr_cnt + 5'd1;
            if (out_fire)
                rd_cnt <= rd_cnt + 4'd1;
        end
    end

`ifdef FFT_INPUT_LOADER_PINGPONG_EN

    logic [DW-1:0] mem [2][32];
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          wbank;
    logic          rbank;

    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign out_a     = mem[rbank][{1'b0, rd_rev}];
    assign out_b     = mem[rbank][{1'b1, rd_rev}];

    // A set always targets an empty bank and a clear a full one, so both can land in one cycle.
    always_comb begin
        full_nxt = full;
        if (wr_done)
            full_nxt[wbank] = 1'b1;
        if (rd_done)
            full_nxt[rbank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_done)
                wbank <= ~wbank;
            if (rd_done)
                rbank <= ~rbank;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire)
            mem[wbank][wr_cnt] <= in_data;
    end

`else

    typedef enum logic {
        LOAD,
        DRAIN
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [32];

    assign out_a = mem[{1'b0, rd_rev}];
    assign out_b = mem[{1'b1, rd_rev}];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (wr_done) begin
                        state     <= DRAIN;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (rd_done) begin
                        state     <= LOAD;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= LOAD;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sample storage carries no reset; outputs are only meaningful once the bank is full.
    always_ff @(posedge clk) begin
        if (in_fire)
            mem[wr_cnt] <= in_data;
    end

`endif

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed-plus-random bench for fft_input_loader; frames are modelled as plain arrays and the
// expected pair order comes from bit-reversing the butterfly index.
module tb_fft_input_loader;

    localparam int DW = 32;
    typedef logic [DW-1:0] frame_t [32];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [3:0]    out_idx;
    logic          out_last;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fft_input_loader #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    function automatic int rev4(int k);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++)
            if ((k >> b) & 1)
                r = r + (8 >> b);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one frame; optionally insist in_ready never drops and check the out_valid latency.
    task automatic applyStimulus(input frame_t f, input bit gap, input bit must_ready, input bit chk_latency);
        for (int n = 0; n < 32; n++) begin
            int budget;
            budget = 0;
            in_valid = 1'b1;
            in_data  = f[n];
            if (must_ready)
                checkOutput("in_ready_hold", in_ready, 1);
            while (!in_ready && budget < 400) begin
                step();
                budget++;
            end
            if (budget >= 400)
                checkOutput("load_timeout", 0, 1);
            if (chk_latency && n == 31)
                checkOutput("valid_before_last", out_valid, 0);
            step();
            in_valid = 1'b0;
            if (chk_latency && n == 31)
                checkOutput("valid_latency", out_valid, 1);
            if (gap)
                step();
        end
    endtask

    // Consume 16 pairs; after_mode 1 expects an idle loader afterwards, 2 expects only in_ready to return.
    task automatic drainFrame(input frame_t f, input int stall_k, input int after_mode);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            int budget;
            budget = 0;
            while (!out_valid && budget < 400) begin
                step();
                budget++;
            end
            if (budget >= 400)
                checkOutput("drain_timeout", 0, 1);
            checkOutput("out_idx", out_idx, k);
            checkOutput("out_a", out_a, f[rev4(k)]);
            checkOutput("out_b", out_b, f[rev4(k) + 16]);
            checkOutput("out_last", out_last, (k == 15));
            if (k == stall_k) begin
                out_ready = 1'b0;
`ifndef FFT_INPUT_LOADER_PINGPONG_EN
                in_valid = 1'b1;
                in_data  = $urandom;
`endif
                for (int s = 0; s < 10; s++) begin
                    step();
                    checkOutput("stall_valid", out_valid, 1);
                    checkOutput("stall_idx", out_idx, k);
                    checkOutput("stall_a", out_a, f[rev4(k)]);
                    checkOutput("stall_b", out_b, f[rev4(k) + 16]);
`ifndef FFT_INPUT_LOADER_PINGPONG_EN
                    checkOutput("stall_in_ready", in_ready, 0);
`endif
                end
`ifndef FFT_INPUT_LOADER_PINGPONG_EN
                in_valid = 1'b0;
`endif
                out_ready = 1'b1;
            end
            if (k == 15 && after_mode == 2)
                checkOutput("ready_before_release", in_ready, 0);
            step();
        end
        out_ready = 1'b0;
        if (after_mode == 1) begin
            checkOutput("idle_out_valid", out_valid, 0);
            checkOutput("idle_in_ready", in_ready, 1);
        end
        if (after_mode == 2)
            checkOutput("ready_after_release", in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before end of sequence");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        frame_t seq;
        frame_t r1;
        frame_t r2;
        frame_t r3;

        for (int n = 0; n < 32; n++)
            seq[n] = DW'(n + 1);

        #12;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_idx", out_idx, 0);
        checkOutput("rst_out_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("[TB] counting frame, continuous flow");
        applyStimulus(seq, 1'b0, 1'b1, 1'b1);
        drainFrame(seq, -1, 1);

        $display("[TB] counting frame, back-pressure at k=3");
        applyStimulus(seq, 1'b0, 1'b1, 1'b1);
        drainFrame(seq, 3, 1);

        $display("[TB] counting frame, in_valid every other cycle");
        applyStimulus(seq, 1'b1, 1'b1, 1'b1);
        drainFrame(seq, -1, 1);

        $display("[TB] reset after a partial frame");
        for (int n = 0; n < 20; n++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_out_idx", out_idx, 0);
        step();
        rst_n = 1'b1;
        step();
        for (int n = 0; n < 32; n++)
            r1[n] = $urandom;
        applyStimulus(r1, 1'b0, 1'b1, 1'b1);
        drainFrame(r1, -1, 1);

        $display("[TB] random frames");
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 32; n++)
                r2[n] = $urandom;
            applyStimulus(r2, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            drainFrame(r2, int'($urandom_range(0, 15)), 1);
        end

`ifdef FFT_INPUT_LOADER_PINGPONG_EN
        $display("[TB] ping-pong: load frame 2 while frame 1 drains");
        for (int n = 0; n < 32; n++) begin
            r1[n] = $urandom;
            r2[n] = $urandom;
        end
        applyStimulus(r1, 1'b0, 1'b1, 1'b1);
        fork
            applyStimulus(r2, 1'b0, 1'b1, 1'b0);
            drainFrame(r1, -1, 0);
        join
        drainFrame(r2, -1, 1);

        $display("[TB] ping-pong: three frames against a stalled consumer");
        for (int n = 0; n < 32; n++) begin
            r1[n] = $urandom;
            r2[n] = $urandom;
            r3[n] = $urandom;
        end
        out_ready = 1'b0;
        applyStimulus(r1, 1'b0, 1'b1, 1'b1);
        applyStimulus(r2, 1'b0, 1'b1, 1'b0);
        checkOutput("ready_after_64", in_ready, 0);
        fork
            applyStimulus(r3, 1'b0, 1'b0, 1'b0);
            drainFrame(r1, -1, 2);
        join
        drainFrame(r2, -1, 0);
        drainFrame(r3, -1, 1);
`else
        for (int n = 0; n < 32; n++)
            r3[n] = $urandom;
        applyStimulus(r3, 1'b0, 1'b1, 1'b1);
        drainFrame(r3, 15, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 SHALL have parameter DW, default 32, real-sample width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  in_data carries a time sample.
REQ-005 SHALL have port in_ready  output  1  loader accepts a sample this cycle.
REQ-006 SHALL have port in_data  input  DW  real time sample, natural order x[0]..x[31].
REQ-007 SHALL have port out_valid  output  1  out_a/out_b carry a stage-1 butterfly pair.
REQ-008 SHALL have port out_ready  input  1  stage-1 consumer accepts the pair.
REQ-009 SHALL have port out_a  output  DW  upper butterfly input x[rev4(k)].
REQ-010 SHALL have port out_b  output  DW  lower butterfly input x[rev4(k)+16].
REQ-011 SHALL have port out_idx  output  4  butterfly index k, 0..15.
REQ-012 SHALL have port out_last  output  1  high when out_idx==15.

Function
REQ-013 SHALL store a frame of 32 samples in a flop array; input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-014 SHALL write the n-th accepted sample of a frame (n = 5-bit write counter, 0..31) to entry n.
REQ-015 SHALL drive, for k = 0..15 in ascending order, out_a = entry rev4(k), out_b = entry rev4(k)+16; rev4 = 4-bit bit reversal (k=1 -> 8/24, k=2 -> 4/20, k=15 -> 15/31).
REQ-016 SHALL derive out_a, out_b, out_idx, out_last combinationally from the read counter and a full bank; values stay stable while out_valid=1 and out_ready=0.
REQ-017 SHALL use states LOAD (in_ready=1, out_valid=0) and DRAIN (in_ready=0, out_valid=1).
REQ-018 SHALL transition LOAD->DRAIN on the input handshake with write counter 31; out_valid rises the following cycle (latency 1 cycle after the 32nd sample).
REQ-019 SHALL transition DRAIN->LOAD on the output handshake with out_idx 15; in_ready rises the following cycle; both counters wrap to 0.
REQ-020 SHALL ignore in_data while in_ready=0 and hold counters while the respective valid or ready is low; back-pressure may last indefinitely.
REQ-021 SHALL pass samples unmodified; no arithmetic, no imaginary part (the consumer pads zero imaginary).

Reset
REQ-022 SHALL, while rst_n=0, force state LOAD, counters 0, out_valid=0, out_idx=0, out_last=0, in_ready=1.
REQ-023 SHALL discard any partially loaded or partially drained frame on reset; the first sample after rst_n rises is x[0] of a new frame.
REQ-024 SHALL leave sample storage unreset; out_a/out_b are don't-care while out_valid=0.

Configuration
REQ-025 SHALL compile two 32-entry banks when macro FFT_INPUT_LOADER_PINGPONG_EN is defined; otherwise a single bank with REQ-017..REQ-019 behaviour.
REQ-026 SHALL, with FFT_INPUT_LOADER_PINGPONG_EN: keep per-bank full flags and write/read bank pointers; in_ready = !full[wbank]; out_valid = full[rbank]; completing a 32-sample write sets full[wbank] and toggles wbank; completing pair 15 clears full[rbank] and toggles rbank.
REQ-027 SHALL, with FFT_INPUT_LOADER_PINGPONG_EN, allow loading of frame N+1 concurrent with draining frame N; set and clear of different banks in the same cycle both take effect; reset clears both flags and both pointers.

Verification
REQ-028 SHALL cover: in_data = n+1 for n=0..31, out_ready=1 -> pairs (1,17),(9,25),(5,21),...,(16,32), out_last only on k=15, out_valid first high 1 cycle after 32nd handshake.
REQ-029 SHALL cover: out_ready=0 for 10 cycles at k=3 -> out_a/out_b hold 13/29, out_idx holds 3, no sample accepted (single bank).
REQ-030 SHALL cover: rst_n pulsed low after 20 samples -> out_valid=0, in_ready=1; next 32 samples form a full clean frame.
REQ-031 SHALL cover: in_valid toggling every other cycle -> frame content identical to REQ-028 stimulus result.
REQ-032 SHALL cover (PINGPONG_EN): two back-to-back frames, out_ready=1 -> in_ready stays high through frame 2 loading while frame 1 drains; frame 2 pairs correct.
REQ-033 SHALL cover (PINGPONG_EN): three frames with out_ready=0 -> in_ready drops after 64th sample, rises 1 cycle after first pair 15 handshake.
